// File: rtl/display_7.sv
// Four-digit hex driver for a common-anode 7-segment display: scans num1..num4
// onto enable[3:0] with registered, active-low anode and segment outputs.
module display_7 #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [3:0] num3,
  input  logic [3:0] num4,
  output logic [7:0] enable,
  output logic [6:0] segment
);

  localparam int               CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       nib;
  logic [7:0]       enable_q, enable_d;
  logic [6:0]       segment_q, segment_d;

  // Active-low gfedcba patterns for hex digits 0..F.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    nib       = num1;
    enable_d  = 8'hFF;
    segment_d = 7'h7F;

    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end

    case (idx_q)
      2'd0:    nib = num1;
      2'd1:    nib = num2;
      2'd2:    nib = num3;
      default: nib = num4;
    endcase

    // Outputs follow the pre-update index, so they lag idx by one cycle.
    enable_d[idx_q] = 1'b0;
    segment_d       = decode(nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      enable_q  <= 8'hFF;
      segment_q <= 7'h7F;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      enable_q  <= enable_d;
      segment_q <= segment_d;
    end
  end

  assign enable  = enable_q;
  assign segment = segment_q;

endmodule

// File: tb/tb_display_7.sv
// Directed bench for display_7: a SCAN_DIV=4 instance for scan/dwell behaviour
// and a SCAN_DIV=1 instance for the decode sweep; both share clock and reset.
module tb_display_7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] num1, num2, num3, num4;
  logic [7:0] enable;
  logic [6:0] segment;
  logic [3:0] f_num1, f_num2, f_num3, f_num4;
  logic [7:0] f_enable;
  logic [6:0] f_segment;

  int n_checks = 0;
  int n_fail   = 0;
  int edges    = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [7:0] en_tab   [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
  // Segment codes for num1..4 = 7,3,F,0.
  logic [6:0] scan_seg [4] = '{7'h78, 7'h30, 7'h0E, 7'h40};

  always #5 clk = ~clk;

  display_7 #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4),
    .enable(enable), .segment(segment)
  );

  display_7 #(.SCAN_DIV(1)) dut_fast (
    .clk(clk), .rst_n(rst_n),
    .num1(f_num1), .num2(f_num2), .num3(f_num3), .num4(f_num4),
    .enable(f_enable), .segment(f_segment)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  function automatic int slow_digit();
    return ((edges - 1) / 4) % 4;
  endfunction

  function automatic int slow_phase();
    return (edges - 1) % 4;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    num1 = 4'h7; num2 = 4'h3; num3 = 4'hF; num4 = 4'h0;
    f_num1 = 4'h0; f_num2 = 4'h0; f_num3 = 4'h0; f_num4 = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (enable !== 8'hFF) begin n_fail++; $display("FAIL reset_enable: got %h want FF", enable); end
    n_checks++;
    if (segment !== 7'h7F) begin n_fail++; $display("FAIL reset_segment: got %h want 7F", segment); end
    n_checks++;
    if (f_enable !== 8'hFF) begin n_fail++; $display("FAIL reset_fast_enable: got %h want FF", f_enable); end
    n_checks++;
    if (f_segment !== 7'h7F) begin n_fail++; $display("FAIL reset_fast_segment: got %h want 7F", f_segment); end
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    tick();
    n_checks++;
    if (enable !== 8'hFE) begin n_fail++; $display("FAIL first_edge_enable: got %h want FE", enable); end
    n_checks++;
    if (segment !== 7'h78) begin n_fail++; $display("FAIL first_edge_segment: got %h want 78", segment); end
    n_checks++;
    if (f_segment !== 7'h40) begin n_fail++; $display("FAIL first_edge_fast_segment: got %h want 40", f_segment); end
  endtask

  task automatic test_full_scan();
    int d;
    for (int i = 0; i < 31; i++) begin
      tick();
      d = slow_digit();
      n_checks++;
      if (enable !== en_tab[d]) begin
        n_fail++; $display("FAIL scan_enable edge %0d: got %h want %h", edges, enable, en_tab[d]);
      end
      n_checks++;
      if (segment !== scan_seg[d]) begin
        n_fail++; $display("FAIL scan_segment edge %0d: got %h want %h", edges, segment, scan_seg[d]);
      end
    end
  endtask

  task automatic test_decode_sweep();
    int guard;
    for (int v = 0; v < 16; v++) begin
      guard = 0;
      while ((edges % 4) != 0 && guard < 8) begin
        tick();
        guard++;
      end
      f_num1 = 4'(v);
      tick();
      n_checks++;
      if (f_segment !== seg_tab[v]) begin
        n_fail++; $display("FAIL decode_%0h: got %h want %h", v, f_segment, seg_tab[v]);
      end
      n_checks++;
      if (f_enable !== 8'hFE) begin
        n_fail++; $display("FAIL decode_enable_%0h: got %h want FE", v, f_enable);
      end
    end
  endtask

  task automatic test_live_update();
    int guard = 0;
    while (!(slow_digit() == 2 && slow_phase() == 0) && guard < 64) begin
      tick();
      guard++;
    end
    n_checks++;
    if (guard >= 64) begin n_fail++; $display("FAIL live_wait: got timeout want digit 2"); end
    n_checks++;
    if (segment !== 7'h0E) begin n_fail++; $display("FAIL live_before: got %h want 0E", segment); end
    num3 = 4'h5;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (segment !== 7'h12) begin n_fail++; $display("FAIL live_segment %0d: got %h want 12", i, segment); end
      n_checks++;
      if (enable !== 8'hFB) begin n_fail++; $display("FAIL live_enable %0d: got %h want FB", i, enable); end
    end
    tick();
    n_checks++;
    if (enable !== 8'hF7 || segment !== 7'h40) begin
      n_fail++; $display("FAIL live_dwell_end: got %h/%h want F7/40", enable, segment);
    end
    num3 = 4'hF;
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (!(slow_digit() == 3 && slow_phase() == 1) && guard < 64) begin
      tick();
      guard++;
    end
    n_checks++;
    if (guard >= 64 || enable !== 8'hF7) begin
      n_fail++; $display("FAIL midrst_wait: got %h want F7", enable);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (enable !== 8'hFF || segment !== 7'h7F) begin
      n_fail++; $display("FAIL midrst_async: got %h/%h want FF/7F", enable, segment);
    end
    n_checks++;
    if (f_enable !== 8'hFF || f_segment !== 7'h7F) begin
      n_fail++; $display("FAIL midrst_async_fast: got %h/%h want FF/7F", f_enable, f_segment);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (enable !== 8'hFF) begin n_fail++; $display("FAIL midrst_hold: got %h want FF", enable); end
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (i < 4 && (enable !== 8'hFE || segment !== 7'h78)) begin
        n_fail++; $display("FAIL midrst_restart %0d: got %h/%h want FE/78", i, enable, segment);
      end else if (i == 4 && (enable !== 8'hFD || segment !== 7'h30)) begin
        n_fail++; $display("FAIL midrst_next: got %h/%h want FD/30", enable, segment);
      end
    end
  endtask

  task automatic test_invariants();
    logic [7:0] prev_en = 8'hFF;
    int         run_len = 0;
    int         n_runs  = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 160; i++) begin
      tick();
      n_checks++;
      if (enable[7:4] !== 4'hF) begin n_fail++; $display("FAIL inv_upper edge %0d: got %h want F", edges, enable[7:4]); end
      n_checks++;
      if ($countones(~enable[3:0]) != 1) begin
        n_fail++; $display("FAIL inv_onehot edge %0d: got %h want one low bit", edges, enable[3:0]);
      end
      n_checks++;
      if (f_enable !== en_tab[(edges - 1) % 4]) begin
        n_fail++; $display("FAIL inv_fast_step edge %0d: got %h want %h", edges, f_enable, en_tab[(edges - 1) % 4]);
      end
      if (enable === prev_en) begin
        run_len++;
      end else begin
        if (prev_en !== 8'hFF) begin
          n_checks++;
          n_runs++;
          if (run_len != 4) begin n_fail++; $display("FAIL inv_dwell edge %0d: got %0d want 4", edges, run_len); end
        end
        run_len = 1;
      end
      prev_en = enable;
    end
    n_checks++;
    if (n_runs != 39) begin n_fail++; $display("FAIL inv_run_count: got %0d want 39", n_runs); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full_scan();
    test_decode_sweep();
    test_live_update();
    test_mid_reset();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
